// File: rtl/cmp_arb.sv
// Two-requester round-robin signed comparator, MSB-first, STEP bits per cycle.
// Latency: done N+1 cycles after the acceptance cycle; accepts every N+2 cycles.
// Backpressure: ready only in IDLE for the granted requester; no queuing, valid must hold until ready.
module cmp_arb #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_op_x,
    input  logic [WIDTH-1:0] a_op_y,
    input  logic [2:0]       a_ctrl,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_op_x,
    input  logic [WIDTH-1:0] b_op_y,
    input  logic [2:0]       b_ctrl,
    output logic             b_ready,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [31:0]      z
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic [2:0]       ctrl_q;
    logic             id_q, last_b_q, grtr_q, eql_q, cond_q;
    logic             grant_b, accept, last_step;
    logic [STEP-1:0]  xs, ys;
    logic             sl_gt, sl_eq, grtr_d, eql_d;

    // B wins only when A is idle or A was the one served last
    assign grant_b   = b_valid & (~a_valid | ~last_b_q);
    assign a_ready   = (state_q == IDLE) & a_valid & ~grant_b;
    assign b_ready   = (state_q == IDLE) & grant_b;
    assign accept    = a_ready | b_ready;
    assign last_step = (cnt_q == CW'(N - 1));

    // Operands shift left each CMP cycle, so the current slice is always on top
    assign xs = x_q[WIDTH-1 -: STEP];
    assign ys = y_q[WIDTH-1 -: STEP];

    // Flags are overwritten on the first slice, then only while still equal
    always_comb begin
        sl_eq  = (xs == ys);
        sl_gt  = (cnt_q == '0) ? ($signed(xs) > $signed(ys)) : (xs > ys);
        grtr_d = grtr_q;
        eql_d  = eql_q;
        if ((cnt_q == '0) || eql_q) begin
            grtr_d = sl_gt;
            eql_d  = sl_eq;
        end
    end

    function automatic logic decode(input logic [2:0] c, input logic g, input logic e);
        case (c)
            3'b000:  decode = ~g & ~e;
            3'b001:  decode = ~g;
            3'b010:  decode = g;
            3'b011:  decode = g | e;
            3'b100:  decode = e;
            3'b101:  decode = ~e;
            default: decode = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CMP;
            CMP:     if (last_step) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ctrl_q   <= '0;
            id_q     <= 1'b0;
            last_b_q <= 1'b1;
            grtr_q   <= 1'b0;
            eql_q    <= 1'b0;
            cond_q   <= 1'b0;
        end else if (accept) begin
            x_q      <= b_ready ? b_op_x : a_op_x;
            y_q      <= b_ready ? b_op_y : a_op_y;
            ctrl_q   <= b_ready ? b_ctrl : a_ctrl;
            id_q     <= b_ready;
            last_b_q <= b_ready;
            cnt_q    <= '0;
        end else if (state_q == CMP) begin
            x_q    <= x_q << STEP;
            y_q    <= y_q << STEP;
            grtr_q <= grtr_d;
            eql_q  <= eql_d;
            if (last_step) begin
                cnt_q  <= '0;
                cond_q <= decode(ctrl_q, grtr_d, eql_d);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == RESP);
    assign done_id = id_q;
    assign z       = {31'b0, cond_q};
endmodule
